// File: rtl/alu_reservation_station.sv
// Unified ALU/branch reservation station.
// Holds up to RS_ENTRIES micro-ops and accepts up to FETCH_W allocations per cycle.
// Sources wake up by snooping two CDB ports. One fully-ready entry, the lowest
// index, moves each cycle into a registered issue slot.
module alu_reservation_station #(
  parameter int FETCH_W    = 2,
  parameter int XLEN       = 32,
  parameter int PHYS_W     = 6,
  parameter int RS_ENTRIES = 16,
  parameter int ROB_W      = 6
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               flush_pipeline,
  input  logic [FETCH_W-1:0]                 rs_alloc_en,
  input  logic [FETCH_W-1:0][PHYS_W-1:0]     rs_alloc_dst_tag,
  input  logic [FETCH_W-1:0][PHYS_W-1:0]     rs_alloc_src1_tag,
  input  logic [FETCH_W-1:0][PHYS_W-1:0]     rs_alloc_src2_tag,
  input  logic [FETCH_W-1:0][63:0]           rs_alloc_src1_val,
  input  logic [FETCH_W-1:0][63:0]           rs_alloc_src2_val,
  input  logic [FETCH_W-1:0]                 rs_alloc_src1_ready,
  input  logic [FETCH_W-1:0]                 rs_alloc_src2_ready,
  input  logic [FETCH_W-1:0][7:0]            rs_alloc_op,
  input  logic [FETCH_W-1:0][ROB_W-1:0]      rs_alloc_rob_tag,
  output logic                               rs_full,
  output logic [$clog2(RS_ENTRIES+1)-1:0]    rs_free_count,
  input  logic [1:0]                         cdb_valid,
  input  logic [1:0][PHYS_W-1:0]             cdb_tag,
  input  logic [1:0][XLEN-1:0]               cdb_value,
  output logic                               issue_valid,
  input  logic                               issue_ready,
  output logic [7:0]                         issue_op,
  output logic [PHYS_W-1:0]                  issue_dst_tag,
  output logic [63:0]                        issue_src1_val,
  output logic [63:0]                        issue_src2_val,
  output logic [ROB_W-1:0]                   issue_rob_tag
);

  localparam int CNT_W = $clog2(RS_ENTRIES + 1);
  localparam int IDX_W = $clog2(RS_ENTRIES);

  // Entry storage
  logic [RS_ENTRIES-1:0] valid_reg;
  logic [7:0]            op_reg     [RS_ENTRIES];
  logic [PHYS_W-1:0]     dst_reg    [RS_ENTRIES];
  logic [ROB_W-1:0]      rob_reg    [RS_ENTRIES];
  logic [PHYS_W-1:0]     s1_tag_reg [RS_ENTRIES];
  logic [PHYS_W-1:0]     s2_tag_reg [RS_ENTRIES];
  logic [63:0]           s1_val_reg [RS_ENTRIES];
  logic [63:0]           s2_val_reg [RS_ENTRIES];
  logic [RS_ENTRIES-1:0] s1_rdy_reg;
  logic [RS_ENTRIES-1:0] s2_rdy_reg;

  logic [CNT_W-1:0]      free_count_reg;

  // Issue slot
  logic                  issue_valid_reg;
  logic [7:0]            issue_op_reg;
  logic [PHYS_W-1:0]     issue_dst_reg;
  logic [63:0]           issue_s1_reg;
  logic [63:0]           issue_s2_reg;
  logic [ROB_W-1:0]      issue_rob_reg;

  // Returns {rdy, val} after snooping both CDB ports; port 1 overrides port 0.
  function automatic logic [64:0] wake_src(
    input logic [PHYS_W-1:0]       tag,
    input logic                    rdy,
    input logic [63:0]             val,
    input logic [1:0]              cv,
    input logic [1:0][PHYS_W-1:0]  ct,
    input logic [1:0][XLEN-1:0]    cval
  );
    logic [64:0] res;
    res = {rdy, val};
    if (!rdy) begin
      for (int p = 0; p < 2; p++) begin
        if (cv[p] && (ct[p] == tag)) res = {1'b1, 64'(cval[p])};
      end
    end
    return res;
  endfunction

  // Wakeup results for stored entries and for incoming allocations
  logic [64:0] s1_wake   [RS_ENTRIES];
  logic [64:0] s2_wake   [RS_ENTRIES];
  logic [64:0] lane_s1_wake [FETCH_W];
  logic [64:0] lane_s2_wake [FETCH_W];

  for (genvar gi = 0; gi < RS_ENTRIES; gi++) begin : g_entry_wake
    assign s1_wake[gi] = wake_src(s1_tag_reg[gi], s1_rdy_reg[gi], s1_val_reg[gi],
                                  cdb_valid, cdb_tag, cdb_value);
    assign s2_wake[gi] = wake_src(s2_tag_reg[gi], s2_rdy_reg[gi], s2_val_reg[gi],
                                  cdb_valid, cdb_tag, cdb_value);
  end

  for (genvar gi = 0; gi < FETCH_W; gi++) begin : g_lane_wake
    assign lane_s1_wake[gi] = wake_src(rs_alloc_src1_tag[gi], rs_alloc_src1_ready[gi],
                                       rs_alloc_src1_val[gi], cdb_valid, cdb_tag, cdb_value);
    assign lane_s2_wake[gi] = wake_src(rs_alloc_src2_tag[gi], rs_alloc_src2_ready[gi],
                                       rs_alloc_src2_val[gi], cdb_valid, cdb_tag, cdb_value);
  end

  assign rs_full = (free_count_reg < CNT_W'(FETCH_W));

  // Free-entry search: each enabled lane claims the lowest entry not already taken
  logic [RS_ENTRIES-1:0] taken;
  logic [FETCH_W-1:0]    alloc_hit;
  logic [IDX_W-1:0]      alloc_idx [FETCH_W];
  logic [FETCH_W-1:0]    lane_go;
  logic [CNT_W-1:0]      n_alloc;
  always_comb begin
    taken   = valid_reg;
    lane_go = '0;
    n_alloc = '0;
    for (int l = 0; l < FETCH_W; l++) begin
      alloc_hit[l] = 1'b0;
      alloc_idx[l] = '0;
      for (int i = 0; i < RS_ENTRIES; i++) begin
        if (!taken[i] && !alloc_hit[l]) begin
          alloc_hit[l] = 1'b1;
          alloc_idx[l] = IDX_W'(i);
        end
      end
      if (rs_alloc_en[l] && alloc_hit[l]) taken[alloc_idx[l]] = 1'b1;
      lane_go[l] = rs_alloc_en[l] && alloc_hit[l] && !rs_full && !flush_pipeline;
      n_alloc    = n_alloc + CNT_W'(lane_go[l]);
    end
  end

  // Select the lowest-index entry whose both sources were ready in registered state
  logic             sel_hit;
  logic [IDX_W-1:0] sel_idx;
  logic             slot_load;
  logic             take;
  always_comb begin
    sel_hit = 1'b0;
    sel_idx = '0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      if (!sel_hit && valid_reg[i] && s1_rdy_reg[i] && s2_rdy_reg[i]) begin
        sel_hit = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
    slot_load = !issue_valid_reg || issue_ready;
    take      = slot_load && sel_hit && !flush_pipeline;
  end

  // Entry array: invalidate on move to slot, wake sources, write new allocations
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_reg  <= '0;
      s1_rdy_reg <= '0;
      s2_rdy_reg <= '0;
      for (int i = 0; i < RS_ENTRIES; i++) begin
        op_reg[i]     <= '0;
        dst_reg[i]    <= '0;
        rob_reg[i]    <= '0;
        s1_tag_reg[i] <= '0;
        s2_tag_reg[i] <= '0;
        s1_val_reg[i] <= '0;
        s2_val_reg[i] <= '0;
      end
    end else if (flush_pipeline) begin
      valid_reg <= '0;
    end else begin
      for (int i = 0; i < RS_ENTRIES; i++) begin
        if (take && (sel_idx == IDX_W'(i))) begin
          valid_reg[i] <= 1'b0;
        end else if (valid_reg[i]) begin
          {s1_rdy_reg[i], s1_val_reg[i]} <= s1_wake[i];
          {s2_rdy_reg[i], s2_val_reg[i]} <= s2_wake[i];
        end
      end
      for (int l = 0; l < FETCH_W; l++) begin
        if (lane_go[l]) begin
          valid_reg[alloc_idx[l]]  <= 1'b1;
          op_reg[alloc_idx[l]]     <= rs_alloc_op[l];
          dst_reg[alloc_idx[l]]    <= rs_alloc_dst_tag[l];
          rob_reg[alloc_idx[l]]    <= rs_alloc_rob_tag[l];
          s1_tag_reg[alloc_idx[l]] <= rs_alloc_src1_tag[l];
          s2_tag_reg[alloc_idx[l]] <= rs_alloc_src2_tag[l];
          {s1_rdy_reg[alloc_idx[l]], s1_val_reg[alloc_idx[l]]} <= lane_s1_wake[l];
          {s2_rdy_reg[alloc_idx[l]], s2_val_reg[alloc_idx[l]]} <= lane_s2_wake[l];
        end
      end
    end
  end

  // Free-entry counter tracks allocations out and slot moves back in
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      free_count_reg <= CNT_W'(RS_ENTRIES);
    end else if (flush_pipeline) begin
      free_count_reg <= CNT_W'(RS_ENTRIES);
    end else begin
      free_count_reg <= free_count_reg - n_alloc + CNT_W'(take);
    end
  end

  // Issue slot: reloads when empty or when the consumer takes the current op
  always_ff @(posedge clk or posedge reset) begin
    if (reset || flush_pipeline) begin
      issue_valid_reg <= 1'b0;
      issue_op_reg    <= '0;
      issue_dst_reg   <= '0;
      issue_s1_reg    <= '0;
      issue_s2_reg    <= '0;
      issue_rob_reg   <= '0;
    end else if (slot_load) begin
      issue_valid_reg <= sel_hit;
      if (sel_hit) begin
        issue_op_reg  <= op_reg[sel_idx];
        issue_dst_reg <= dst_reg[sel_idx];
        issue_s1_reg  <= s1_val_reg[sel_idx];
        issue_s2_reg  <= s2_val_reg[sel_idx];
        issue_rob_reg <= rob_reg[sel_idx];
      end
    end
  end

  assign rs_free_count  = free_count_reg;
  assign issue_valid    = issue_valid_reg;
  assign issue_op       = issue_op_reg;
  assign issue_dst_tag  = issue_dst_reg;
  assign issue_src1_val = issue_s1_reg;
  assign issue_src2_val = issue_s2_reg;
  assign issue_rob_tag  = issue_rob_reg;

endmodule
